// File: rtl/clkdivn_sync_pkg.sv
// Shared types for the clkdivn_sync clock-ratio bridge.
//   cmd_t           PHY command encoding
//   pkt_t           PHY/data-handler packet word
//   cfr_*_t         configuration words, with their reset values cfr_*_init
//   DIV_MAX         largest supported fast:slow clock ratio
package clkdivn_sync_pkg;

  localparam int DIV_MAX = 8;

  typedef enum logic [2:0] {
    NOP1 = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CONF = 3'd3,
    REFR = 3'd4
  } cmd_t;

  typedef logic [15:0] pkt_t;
  typedef logic [3:0]  cfr_mode_t;
  typedef logic [7:0]  cfr_time_t;
  typedef logic [3:0]  cfr_schd_t;

  localparam cfr_mode_t cfr_mode_init = 4'h1;
  localparam cfr_time_t cfr_time_init = 8'h10;
  localparam cfr_schd_t cfr_schd_init = 4'h2;

endpackage

// File: rtl/clkdivn_sync_resp_fifo.sv
// sync_resp_fifo: single-clock response queue for the fast->slow path.
//   clk, rst        fast clock, async active-high reset (empties the queue)
//   push, din       write request / data; ignored when full unless popping
//   pop, dout       read request / head of queue (valid while !empty)
//   empty, full     status flags
//   level           occupancy, 0..DEPTH
module sync_resp_fifo
  import clkdivn_sync_pkg::*;
#(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  // Extra MSB on the pointers distinguishes full from empty on wrap.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A simultaneous pop frees the head slot, so a push on full is still accepted.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/clkdivn_sync.sv
// clkdivn_sync: bridge between the slow PHY clock domain and the fast core
// clock clk (integer ratio DIV:1, phase-aligned).
//   clk, rst, resync          fast clock, async active-high reset, phase re-acquire pulse
//   cal_done..cfr_schd_p      slow-domain PHY inputs
//   *_sync                    fast-domain copies; commands issued for one fast cycle
//   intf_*_dh, temp_*_dh      fast-domain responses / temperature from the data handler
//   intf_*, temp_*            PHY-side copies, updated once per slow period
//   locked, resp_ovf, resp_level  phase lock, sticky drop flag, queue occupancy
module clkdivn_sync
  import clkdivn_sync_pkg::*;
#(
  parameter int DIV        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          resync,
  input  logic                          cal_done,
  input  logic                          ck_en,
  input  logic                          wck_en,
  input  logic                          pkt_valid,
  input  cmd_t                          cmd,
  input  pkt_t                          pkt,
  input  cfr_mode_t                     cfr_mode_p,
  input  cfr_time_t                     cfr_time_p,
  input  cfr_schd_t                     cfr_schd_p,
  output logic                          cal_done_sync,
  output logic                          ck_en_sync,
  output logic                          wck_en_sync,
  output logic                          pkt_valid_sync,
  output cmd_t                          cmd_sync,
  output pkt_t                          pkt_sync,
  output cfr_mode_t                     cfr_mode_sync,
  output cfr_time_t                     cfr_time_sync,
  output cfr_schd_t                     cfr_schd_sync,
  input  logic                          intf_pkt_valid_dh,
  input  logic                          intf_pkt_retry_dh,
  input  pkt_t                          intf_pkt_dh,
  input  logic [31:0]                   intf_edc_dh,
  input  logic                          temp_valid_dh,
  input  logic [7:0]                    temp_data_dh,
  output logic                          intf_pkt_valid,
  output logic                          intf_pkt_retry,
  output pkt_t                          intf_pkt,
  output logic [31:0]                   intf_edc,
  output logic                          temp_valid,
  output logic [7:0]                    temp_data,
  output logic                          locked,
  output logic                          resp_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   resp_level
);

  localparam int PH_W = $clog2(DIV_MAX);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam int EW = 1 + $bits(pkt_t) + 32;

  logic [PH_W-1:0] ph;
  logic            cap;
  logic            first_q;
  logic            valid_buf;
  cmd_t            cmd_buf;
  logic            issue;

  logic            pend;
  logic [7:0]      tdat;

  logic            f_empty, f_full, f_pop;
  logic [EW-1:0]   f_din, f_dout;

  // Phase tracker: lock on first command, cap marks the last fast cycle of each slow period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      ph     <= '0;
    end else if (resync) begin
      locked <= 1'b0;
      ph     <= '0;
    end else if (!locked) begin
      if (pkt_valid) begin
        locked <= 1'b1;
        ph     <= '0;
      end
    end else begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  assign cap = locked && (ph == PH_LAST);

  // Slow->fast capture buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_done_sync <= 1'b0;
      ck_en_sync    <= 1'b0;
      wck_en_sync   <= 1'b0;
      pkt_sync      <= '0;
      cfr_mode_sync <= cfr_mode_init;
      cfr_time_sync <= cfr_time_init;
      cfr_schd_sync <= cfr_schd_init;
      valid_buf     <= 1'b0;
      cmd_buf       <= NOP1;
      first_q       <= 1'b0;
    end else begin
      first_q <= cap;
      if (cap) begin
        cal_done_sync <= cal_done;
        ck_en_sync    <= ck_en;
        wck_en_sync   <= wck_en;
        pkt_sync      <= pkt;
        cfr_mode_sync <= cfr_mode_p;
        cfr_time_sync <= cfr_time_p;
        cfr_schd_sync <= cfr_schd_p;
        valid_buf     <= pkt_valid;
        cmd_buf       <= cmd;
      end
    end
  end

  // Normal commands fire once per capture; CONF stays asserted so reset-time
  // configuration logic sees it on every fast cycle.
  assign issue          = first_q || (cmd_buf == CONF);
  assign pkt_valid_sync = issue ? valid_buf : 1'b0;
  assign cmd_sync       = issue ? cmd_buf : NOP1;

  // Fast->slow response queue.
  assign f_din = {intf_pkt_retry_dh, intf_pkt_dh, intf_edc_dh};
  assign f_pop = cap & ~f_empty;

  sync_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (intf_pkt_valid_dh),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full),
    .level (resp_level)
  );

  // PHY-side response registers, temperature slot and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intf_pkt_valid <= 1'b0;
      intf_pkt_retry <= 1'b0;
      intf_pkt       <= '0;
      intf_edc       <= '0;
      temp_valid     <= 1'b0;
      temp_data      <= '0;
      pend           <= 1'b0;
      tdat           <= '0;
      resp_ovf       <= 1'b0;
    end else begin
      if (intf_pkt_valid_dh && f_full && !f_pop) resp_ovf <= 1'b1;

      if (temp_valid_dh) tdat <= temp_data_dh;

      if (cap) begin
        intf_pkt_valid <= ~f_empty;
        if (!f_empty) begin
          {intf_pkt_retry, intf_pkt, intf_edc} <= f_dout;
        end else begin
          intf_pkt_retry <= 1'b0;
        end
        // A sample arriving on the capture cycle goes straight through.
        temp_valid <= pend | temp_valid_dh;
        temp_data  <= temp_valid_dh ? temp_data_dh : tdat;
        pend       <= 1'b0;
      end else if (temp_valid_dh) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clkdivn_sync.sv
// Directed bench: two bridges (DIV=2 and DIV=4) driven by the same stimulus.
module tb_clkdivn_sync;
  import clkdivn_sync_pkg::*;

  logic clk = 1'b0, rst = 1'b1, resync = 1'b0;
  logic cal_done = 1'b0, ck_en = 1'b0, wck_en = 1'b0, pkt_valid = 1'b0;
  cmd_t cmd = NOP1;
  pkt_t pkt = '0;
  cfr_mode_t cfr_mode_p = 4'hA;
  cfr_time_t cfr_time_p = 8'h5C;
  cfr_schd_t cfr_schd_p = 4'h7;
  logic intf_pkt_valid_dh = 1'b0, intf_pkt_retry_dh = 1'b0;
  pkt_t intf_pkt_dh = '0;
  logic [31:0] intf_edc_dh = '0;
  logic temp_valid_dh = 1'b0;
  logic [7:0] temp_data_dh = '0;

  logic a_cal, a_ck, a_wck, a_pv, a_ipv, a_ret, a_tv, a_lock, a_ovf;
  cmd_t a_cmd; pkt_t a_pkt, a_ipkt; cfr_mode_t a_cm; cfr_time_t a_ct; cfr_schd_t a_cs;
  logic [31:0] a_edc; logic [7:0] a_td; logic [2:0] a_lvl;
  logic b_cal, b_ck, b_wck, b_pv, b_ipv, b_ret, b_tv, b_lock, b_ovf;
  cmd_t b_cmd; pkt_t b_pkt, b_ipkt; cfr_mode_t b_cm; cfr_time_t b_ct; cfr_schd_t b_cs;
  logic [31:0] b_edc; logic [7:0] b_td; logic [2:0] b_lvl;

  int n_vec = 0, n_err = 0, k = 0;
  int n2, n4;

  always #5 clk = ~clk;

  clkdivn_sync #(.DIV(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .resync(resync), .cal_done(cal_done), .ck_en(ck_en), .wck_en(wck_en),
    .pkt_valid(pkt_valid), .cmd(cmd), .pkt(pkt), .cfr_mode_p(cfr_mode_p), .cfr_time_p(cfr_time_p),
    .cfr_schd_p(cfr_schd_p), .cal_done_sync(a_cal), .ck_en_sync(a_ck), .wck_en_sync(a_wck),
    .pkt_valid_sync(a_pv), .cmd_sync(a_cmd), .pkt_sync(a_pkt), .cfr_mode_sync(a_cm),
    .cfr_time_sync(a_ct), .cfr_schd_sync(a_cs), .intf_pkt_valid_dh(intf_pkt_valid_dh),
    .intf_pkt_retry_dh(intf_pkt_retry_dh), .intf_pkt_dh(intf_pkt_dh), .intf_edc_dh(intf_edc_dh),
    .temp_valid_dh(temp_valid_dh), .temp_data_dh(temp_data_dh), .intf_pkt_valid(a_ipv),
    .intf_pkt_retry(a_ret), .intf_pkt(a_ipkt), .intf_edc(a_edc), .temp_valid(a_tv),
    .temp_data(a_td), .locked(a_lock), .resp_ovf(a_ovf), .resp_level(a_lvl));

  clkdivn_sync #(.DIV(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .resync(resync), .cal_done(cal_done), .ck_en(ck_en), .wck_en(wck_en),
    .pkt_valid(pkt_valid), .cmd(cmd), .pkt(pkt), .cfr_mode_p(cfr_mode_p), .cfr_time_p(cfr_time_p),
    .cfr_schd_p(cfr_schd_p), .cal_done_sync(b_cal), .ck_en_sync(b_ck), .wck_en_sync(b_wck),
    .pkt_valid_sync(b_pv), .cmd_sync(b_cmd), .pkt_sync(b_pkt), .cfr_mode_sync(b_cm),
    .cfr_time_sync(b_ct), .cfr_schd_sync(b_cs), .intf_pkt_valid_dh(intf_pkt_valid_dh),
    .intf_pkt_retry_dh(intf_pkt_retry_dh), .intf_pkt_dh(intf_pkt_dh), .intf_edc_dh(intf_edc_dh),
    .temp_valid_dh(temp_valid_dh), .temp_data_dh(temp_data_dh), .intf_pkt_valid(b_ipv),
    .intf_pkt_retry(b_ret), .intf_pkt(b_ipkt), .intf_edc(b_edc), .temp_valid(b_tv),
    .temp_data(b_td), .locked(b_lock), .resp_ovf(b_ovf), .resp_level(b_lvl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    // Reset state
    chk("rst_cmd2", a_cmd, NOP1);       chk("rst_cmd4", b_cmd, NOP1);
    chk("rst_cfrm", a_cm, 32'h1);       chk("rst_cfrt", b_ct, 32'h10);
    chk("rst_cfrs", b_cs, 32'h2);       chk("rst_lock", {a_lock, b_lock}, 0);
    chk("rst_lvl", {a_lvl, b_lvl}, 0);  chk("rst_ipv", {a_ipv, b_ipv, a_ovf, b_ovf}, 0);
    chk("rst_pv", {a_pv, b_pv, a_cal, b_cal}, 0);

    // Lock and single-cycle command issue
    cal_done = 1'b1; pkt_valid = 1'b1; cmd = RD; pkt = 16'hA5A5;
    tick();
    chk("lock", {a_lock, b_lock}, 2'b11);
    chk("cmd_pre2", a_cmd, NOP1);
    while (k < 13) begin
      tick();
      chk("pv2", a_pv, (k >= 3 && k % 2 == 1));
      chk("cmd2", a_cmd, (k >= 3 && k % 2 == 1) ? RD : NOP1);
      chk("pv4", b_pv, (k % 4 == 1));
      chk("cmd4", b_cmd, (k % 4 == 1) ? RD : NOP1);
      chk("cal2", a_cal, k >= 3);
      chk("cal4", b_cal, k >= 5);
      chk("cfrm4", b_cm, (k >= 5) ? 32'hA : 32'h1);
    end
    chk("pkt4", b_pkt, 16'hA5A5);

    // CONF held: asserted on every fast cycle
    cmd = CONF;
    while (k < 24) begin
      tick();
      chk("conf2", a_cmd, (k >= 15) ? CONF : NOP1);
      chk("confpv2", a_pv, k >= 15);
      chk("conf4", b_cmd, (k >= 17) ? CONF : NOP1);
      chk("confpv4", b_pv, k >= 17);
    end
    cmd = NOP1; pkt_valid = 1'b0;
    tick();
    chk("idle", {a_pv, b_pv, 3'(a_cmd), 3'(b_cmd)}, 0);

    // Three back-to-back responses A,B(retry),C plus temperature
    intf_pkt_valid_dh = 1'b1; intf_pkt_dh = 16'h000A; intf_edc_dh = 32'hEDC0000A;
    temp_valid_dh = 1'b1; temp_data_dh = 8'h55;
    tick();                                             // k=26
    intf_pkt_dh = 16'h000B; intf_edc_dh = 32'hEDC0000B; intf_pkt_retry_dh = 1'b1;
    temp_valid_dh = 1'b0;
    tick();                                             // k=27
    chk("r2_A", {a_ipv, a_ret, a_ipkt}, {2'b10, 16'h000A});
    chk("r2_edcA", a_edc, 32'hEDC0000A);
    chk("t2_1", {a_tv, a_td}, {1'b1, 8'h55});
    chk("lvl4_2", b_lvl, 2);
    intf_pkt_dh = 16'h000C; intf_edc_dh = 32'hEDC0000C; intf_pkt_retry_dh = 1'b0;
    tick();                                             // k=28
    chk("lvl2_2", a_lvl, 2);
    chk("lvl4_3", b_lvl, 3);
    intf_pkt_valid_dh = 1'b0;
    tick();                                             // k=29
    chk("r2_B", {a_ipv, a_ret, a_ipkt}, {2'b11, 16'h000B});
    chk("r2_edcB", a_edc, 32'hEDC0000B);
    chk("t2_0", a_tv, 0);
    chk("r4_A", {b_ipv, b_ret, b_ipkt}, {2'b10, 16'h000A});
    chk("t4_1", {b_tv, b_td}, {1'b1, 8'h55});
    chk("lvl4_29", b_lvl, 2);
    tick(); tick();                                     // k=31
    chk("r2_C", {a_ipv, a_ret, a_ipkt}, {2'b10, 16'h000C});
    tick();                                             // k=32
    temp_valid_dh = 1'b1; temp_data_dh = 8'hAA;
    tick();                                             // k=33: bypass
    temp_valid_dh = 1'b0;
    chk("r2_empty", {a_ipv, a_ret, a_ipkt}, {2'b00, 16'h000C});
    chk("lvl2_0", a_lvl, 0);
    chk("r4_B", {b_ipv, b_ret, b_ipkt}, {2'b11, 16'h000B});
    chk("lvl4_1", b_lvl, 1);
    chk("tbyp2", {a_tv, a_td}, {1'b1, 8'hAA});
    chk("tbyp4", {b_tv, b_td}, {1'b1, 8'hAA});
    while (k < 37) tick();
    chk("r4_C", {b_ipv, b_ret, b_ipkt}, {2'b10, 16'h000C});
    chk("t4_0", b_tv, 0);
    while (k < 41) tick();
    chk("r4_empty", {b_ipv, b_ret, b_ipkt}, {2'b00, 16'h000C});

    // Overflow while unlocked
    resync = 1'b1;
    tick();                                             // k=42
    resync = 1'b0;
    chk("unlock", {a_lock, b_lock}, 0);
    for (int i = 1; i <= 6; i++) begin
      intf_pkt_valid_dh = 1'b1; intf_pkt_dh = 16'(i); intf_edc_dh = 32'(i);
      tick();
    end
    intf_pkt_valid_dh = 1'b0;
    chk("ovf_lvl", {a_lvl, b_lvl}, {3'd4, 3'd4});
    chk("ovf_flag", {a_ovf, b_ovf}, 2'b11);
    chk("ovf_hold", {a_ipv, b_ipv}, 0);
    pkt_valid = 1'b1;
    tick();                                             // k=49
    pkt_valid = 1'b0;
    chk("relock", {a_lock, b_lock}, 2'b11);
    while (k < 69) begin
      tick();
      n2 = (k >= 51) ? (k - 51) / 2 + 1 : 0;
      n4 = (k >= 53) ? (k - 53) / 4 + 1 : 0;
      chk("drain2_v", a_ipv, (n2 >= 1 && n2 <= 4));
      if (n2 >= 1 && n2 <= 4) chk("drain2_d", a_ipkt, n2);
      chk("drain4_v", b_ipv, (n4 >= 1 && n4 <= 4));
      if (n4 >= 1 && n4 <= 4) chk("drain4_d", b_ipkt, n4);
    end
    chk("ovf_sticky", {a_ovf, b_ovf}, 2'b11);

    // Reset in the middle of a queue
    resync = 1'b1;
    tick();
    resync = 1'b0;
    intf_pkt_valid_dh = 1'b1; intf_pkt_dh = 16'h1111;
    tick();
    intf_pkt_dh = 16'h2222;
    tick();
    intf_pkt_valid_dh = 1'b0;
    chk("mq_lvl", {a_lvl, b_lvl}, {3'd2, 3'd2});
    chk("mq_cfr", b_cm, 32'hA);
    #2 rst = 1'b1;
    #1;
    chk("mr_lvl", {a_lvl, b_lvl}, 0);
    chk("mr_ovf", {a_ovf, b_ovf, a_lock, b_lock}, 0);
    chk("mr_ipkt", {b_ipkt, a_ipkt}, 0);
    chk("mr_cfr2", {a_cm, a_ct, a_cs}, {4'h1, 8'h10, 4'h2});
    chk("mr_cfr4", {b_cm, b_ct, b_cs}, {4'h1, 8'h10, 4'h2});
    chk("mr_cmd", {3'(a_cmd), 3'(b_cmd), a_cal, b_cal}, 0);
    #2 rst = 1'b0;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("mr_relock", {a_lock, b_lock}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
